// File: rtl/hi_lo_multiply_divide_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : hi_lo_multiply_divide_unit_if
// Description : Execute-stage command/result bundle between the pipeline and
//               the HI/LO multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface hi_lo_multiply_divide_unit_if;
    logic [5:0]  ALU_function;
    logic        HI_register_write;
    logic        LO_register_write;
    logic        using_HI_LO;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        busy;
    logic        stall;

    modport master (
        output ALU_function, HI_register_write, LO_register_write, using_HI_LO,
               operand_a, operand_b,
        input  HI, LO, busy, stall
    );

    modport slave (
        input  ALU_function, HI_register_write, LO_register_write, using_HI_LO,
               operand_a, operand_b,
        output HI, LO, busy, stall
    );
endinterface
`default_nettype wire

// File: rtl/hi_lo_multiply_divide_unit.sv
`default_nettype none
// ============================================================================
// Module      : hi_lo_multiply_divide_unit
// Description : Architectural HI/LO registers with iterative MULT/MULTU/DIV/DIVU
//               (shift-add / restoring divide) and single-cycle MTHI/MTLO.
// Revision    : 1.0 - initial release
// ============================================================================
module hi_lo_multiply_divide_unit #(
    parameter int ITERATIONS = 32
) (
    input  wire logic clk,
    input  wire logic reset_n,
    hi_lo_multiply_divide_unit_if.slave bus
);

    localparam int          CNT_W       = $clog2(ITERATIONS + 1);
    localparam logic [5:0]  FUNCT_MULT  = 6'b011000;
    localparam logic [5:0]  FUNCT_MULTU = 6'b011001;
    localparam logic [5:0]  FUNCT_DIV   = 6'b011010;
    localparam logic [5:0]  FUNCT_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   count_q;
    logic [31:0]        hi_q;
    logic [31:0]        lo_q;
    logic [63:0]        acc_q;
    logic [31:0]        opnd_q;
    logic [31:0]        src_a_q;
    logic               is_div_q;
    logic               neg_res_q;
    logic               neg_rem_q;
    logic               div_zero_q;

    logic               w_is_muldiv;
    logic               w_signed_op;
    logic               w_start;
    logic               w_mt_hi;
    logic               w_mt_lo;
    logic               w_busy;
    logic               w_sign_a;
    logic               w_sign_b;
    logic [31:0]        w_mag_a;
    logic [31:0]        w_mag_b;
    logic [32:0]        w_mul_sum;
    logic [63:0]        w_mul_next;
    logic [32:0]        w_div_shift;
    logic [32:0]        w_div_diff;
    logic [63:0]        w_div_next;

    assign w_is_muldiv = (bus.ALU_function == FUNCT_MULT)  || (bus.ALU_function == FUNCT_MULTU) ||
                         (bus.ALU_function == FUNCT_DIV)   || (bus.ALU_function == FUNCT_DIVU);
    assign w_signed_op = (bus.ALU_function == FUNCT_MULT)  || (bus.ALU_function == FUNCT_DIV);
    assign w_start     = bus.HI_register_write & bus.LO_register_write & w_is_muldiv;
    assign w_mt_hi     = bus.HI_register_write & ~bus.LO_register_write;
    assign w_mt_lo     = bus.LO_register_write & ~bus.HI_register_write;

    assign w_sign_a    = w_signed_op & bus.operand_a[31];
    assign w_sign_b    = w_signed_op & bus.operand_b[31];
    assign w_mag_a     = w_sign_a ? -bus.operand_a : bus.operand_a;
    assign w_mag_b     = w_sign_b ? -bus.operand_b : bus.operand_b;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    assign w_mul_sum   = {1'b0, acc_q[63:32]} + {1'b0, opnd_q};
    assign w_mul_next  = acc_q[0] ? {w_mul_sum, acc_q[31:1]} : {1'b0, acc_q[63:1]};

    // Divide: acc = {partial remainder, dividend/quotient bits}; borrow in bit 32 means restore.
    assign w_div_shift = acc_q[63:31];
    assign w_div_diff  = w_div_shift - {1'b0, opnd_q};
    assign w_div_next  = w_div_diff[32] ? {acc_q[62:0], 1'b0}
                                        : {w_div_diff[31:0], acc_q[30:0], 1'b1};

    assign w_busy      = (state_q != ST_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            src_a_q    <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_start) begin
                        state_q    <= ST_RUN;
                        count_q    <= '0;
                        acc_q      <= {32'd0, w_mag_a};
                        opnd_q     <= w_mag_b;
                        src_a_q    <= bus.operand_a;
                        is_div_q   <= bus.ALU_function[1];
                        neg_res_q  <= w_sign_a ^ w_sign_b;
                        neg_rem_q  <= w_sign_a;
                        div_zero_q <= bus.ALU_function[1] && (bus.operand_b == 32'd0);
                    end else begin
                        if (w_mt_hi) hi_q <= bus.operand_a;
                        if (w_mt_lo) lo_q <= bus.operand_a;
                    end
                end
                ST_RUN: begin
                    acc_q   <= is_div_q ? w_div_next : w_mul_next;
                    count_q <= count_q + 1'b1;
                    if (count_q == CNT_W'(ITERATIONS - 1)) state_q <= ST_FINISH;
                end
                ST_FINISH: begin
                    state_q <= ST_IDLE;
                    if (!is_div_q) begin
                        {hi_q, lo_q} <= neg_res_q ? -acc_q : acc_q;
                    end else if (div_zero_q) begin
                        hi_q <= src_a_q;
                        lo_q <= 32'hFFFF_FFFF;
                    end else begin
                        lo_q <= neg_res_q ? -acc_q[31:0]  : acc_q[31:0];
                        hi_q <= neg_rem_q ? -acc_q[63:32] : acc_q[63:32];
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.HI    = hi_q;
    assign bus.LO    = lo_q;
    assign bus.busy  = w_busy;
    assign bus.stall = w_busy & (bus.using_HI_LO | bus.HI_register_write | bus.LO_register_write);

endmodule
`default_nettype wire
